// File: rtl/modport_ram.sv
// Simple dual-port 4096x64 synchronous RAM with per-entry written flags.
// Optional MODPORT_RAM_BYPASS_EN: write-first forwarding on same-address collision.
module modport_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wr_add,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] rd_add,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  rd_valid
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_flag;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Array has no reset so it can map onto RAM macros; the flags mask stale data.
  always_ff @(posedge clk) begin
    if (rst_n && wr) begin
      r_mem[wr_add] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flag <= '0;
    end else if (wr) begin
      r_flag[wr_add] <= 1'b1;
    end
  end

  assign w_rd_data = r_flag[rd_add] ? r_mem[rd_add] : '0;

`ifdef MODPORT_RAM_BYPASS_EN
  logic w_collide;
  assign w_collide = wr && (wr_add == rd_add);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_rd_valid <= 1'b0;
    end else if (rd) begin
      r_out      <= w_collide ? in : w_rd_data;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end
`else
  // Nonblocking update of r_mem gives read-first on collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_rd_valid <= 1'b0;
    end else if (rd) begin
      r_out      <= w_rd_data;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end
`endif

  assign out      = r_out;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_modport_ram.sv
// Self-checking bench for modport_ram: directed scenarios plus randomized traffic
// checked against an array-based behavioural model.
module tb_modport_ram;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [11:0] wr_add;
  logic [63:0] in;
  logic        rd;
  logic [11:0] rd_add;
  logic [63:0] out;
  logic        rd_valid;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_mem  [4096];
  bit          m_flag [4096];
  logic [63:0] exp_out;
  logic        exp_vld;

`ifdef MODPORT_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  modport_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .wr_add   (wr_add),
    .in       (in),
    .rd       (rd),
    .rd_add   (rd_add),
    .out      (out),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge: update the reference model from the values presented, then settle.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      exp_out = '0;
      exp_vld = 1'b0;
      for (int i = 0; i < 4096; i++) m_flag[i] = 1'b0;
    end else begin
      if (rd) begin
        if (BYPASS && wr && wr_add == rd_add) exp_out = in;
        else exp_out = m_flag[rd_add] ? m_mem[rd_add] : 64'h0;
        exp_vld = 1'b1;
      end else begin
        exp_vld = 1'b0;
      end
      if (wr) begin
        m_mem[wr_add]  = in;
        m_flag[wr_add] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    cyc(); cyc();
    checks++;
    if (out !== 64'h0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out=%h rd_valid=%b expected out=0 rd_valid=0", out, rd_valid);
    end
    rst_n = 1'b1; rd = 1'b1; rd_add = 12'h000;
    cyc();
    checks++;
    if (out !== 64'h0 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_then_read out=%h rd_valid=%b expected out=0 rd_valid=1", out, rd_valid);
    end
    idle();
  endtask

  task automatic test_write_read();
    wr = 1'b1; wr_add = 12'h0A5; in = 64'hDEAD_BEEF_0123_4567;
    cyc();
    idle(); rd = 1'b1; rd_add = 12'h0A5;
    cyc();
    checks++;
    if (out !== 64'hDEAD_BEEF_0123_4567 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL write_read out=%h rd_valid=%b expected out=deadbeef01234567 rd_valid=1", out, rd_valid);
    end
    idle();
  endtask

  task automatic test_collision();
    logic [63:0] want;
    wr = 1'b1; wr_add = 12'h100; in = 64'h1111;
    cyc();
    rd = 1'b1; rd_add = 12'h100; in = 64'h2222;
    cyc();
    want = BYPASS ? 64'h2222 : 64'h1111;
    checks++;
    if (out !== want || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL collision out=%h rd_valid=%b expected out=%h rd_valid=1", out, rd_valid, want);
    end
    wr = 1'b0;
    cyc();
    checks++;
    if (out !== 64'h2222) begin
      failures++;
      $display("FAIL collision_after out=%h expected 2222", out);
    end
    // Collision on a never-written location
    wr = 1'b1; wr_add = 12'h7E3; in = 64'h3333; rd_add = 12'h7E3;
    cyc();
    want = BYPASS ? 64'h3333 : 64'h0;
    checks++;
    if (out !== want) begin
      failures++;
      $display("FAIL collision_fresh out=%h expected %h", out, want);
    end
    idle();
  endtask

  task automatic test_boundary();
    wr = 1'b1; wr_add = 12'hFFF; in = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    wr_add = 12'h000; in = 64'h1;
    cyc();
    wr = 1'b0; rd = 1'b1; rd_add = 12'hFFF;
    cyc();
    checks++;
    if (out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++;
      $display("FAIL boundary_fff out=%h expected ffffffffffffffff", out);
    end
    rd_add = 12'h000;
    cyc();
    checks++;
    if (out !== 64'h1) begin
      failures++;
      $display("FAIL boundary_000 out=%h expected 1", out);
    end
    idle();
  endtask

  task automatic test_reset_clears();
    wr = 1'b1; wr_add = 12'h010; in = 64'hABCD;
    cyc();
    rst_n = 1'b0; wr_add = 12'h020; in = 64'h5555; rd = 1'b1; rd_add = 12'h010;
    cyc();
    checks++;
    if (out !== 64'h0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulse out=%h rd_valid=%b expected out=0 rd_valid=0", out, rd_valid);
    end
    rst_n = 1'b1; wr = 1'b0; rd_add = 12'h010;
    cyc();
    checks++;
    if (out !== 64'h0 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_clears out=%h rd_valid=%b expected out=0 rd_valid=1", out, rd_valid);
    end
    rd_add = 12'h020;
    cyc();
    checks++;
    if (out !== 64'h0) begin
      failures++;
      $display("FAIL reset_drops_write out=%h expected 0", out);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 16; a++) begin
      wr = 1'b1; wr_add = 12'(a); in = 64'(a + 1);
      cyc();
    end
    wr = 1'b0; rd = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_add = 12'(a);
      cyc();
      checks++;
      if (out !== 64'(a + 1) || rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back addr=%0d out=%h rd_valid=%b expected out=%h rd_valid=1",
                 a, out, rd_valid, 64'(a + 1));
      end
    end
    rd = 1'b0; rd_add = 'x;
    cyc(); cyc();
    checks++;
    if (out !== 64'h10 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold out=%h rd_valid=%b expected out=10 rd_valid=0", out, rd_valid);
    end
    rd_add = 12'h0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      wr     = $urandom_range(0, 1);
      rd     = $urandom_range(0, 1);
      wr_add = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      rd_add = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      in     = {$urandom, $urandom};
      cyc();
      checks++;
      if (out !== exp_out || rd_valid !== exp_vld) begin
        failures++;
        $display("FAIL random n=%0d out=%h rd_valid=%b expected out=%h rd_valid=%b",
                 n, out, rd_valid, exp_out, exp_vld);
      end
    end
    rst_n = 1'b1; idle();
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0;
    wr_add = '0; rd_add = '0; in = '0;
    exp_out = '0; exp_vld = 1'b0;
    test_reset();
    test_write_read();
    test_collision();
    test_boundary();
    test_reset_clears();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
